// File: rtl/atommc_pic_responder.sv
// atommc_pic_responder: PIC-side AtoMMC register window with command handshake and data FIFOs
module atommc_pic_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok = pop & !empty;
  assign push_ok = push & (!full | pop);
  assign rdata = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  // storage write; a full FIFO with a pop frees the slot being written
  always_ff @(posedge Clk)
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  // pointer advance, wrapping modulo 2*DEPTH
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE;
      if (pop_ok) rd_ptr <= rd_ptr + ONE;
    end
endmodule

module atommc_pic_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PIC_nRD,
  input  logic       PIC_nWR,
  input  logic       PIC_nEn,
  input  logic [2:0] PIC_Addr,
  input  logic [7:0] PIC_Data_In,
  output logic [7:0] PIC_Data_Out,
  output logic       PIC_Data_OE,
  output logic [7:0] Cmd_Code,
  output logic [7:0] Cmd_Latch,
  output logic       Cmd_Valid,
  input  logic       Cmd_Done,
  input  logic [3:0] Cmd_Result,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  output logic       Tx_Ready,
  output logic [7:0] Rx_Data,
  output logic       Rx_Valid,
  input  logic       Rx_Ready
);
  logic [SYNC_STAGES-1:0] rd_s, wr_s, fill;
  logic rd_h, wr_h, rd_arm, wr_arm;
  logic rd_sync, wr_sync, rd_edge, wr_edge;
  logic [7:0] cap, latch, tx_head, status;
  logic busy, err;
  logic [3:0] result;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic wr_cmd, wr_lat, rd_stat, rd_tx, busy_eff, accept, err_set;
  assign rd_sync = rd_s[SYNC_STAGES-1];
  assign wr_sync = wr_s[SYNC_STAGES-1];
  assign rd_edge = rd_arm & rd_sync & !rd_h;
  assign wr_edge = wr_arm & wr_sync & !wr_h;
  // strobe synchronisers; an edge is only armed once the chain has seen the strobe idle after reset
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      rd_s <= '1;
      wr_s <= '1;
      rd_h <= 1'b1;
      wr_h <= 1'b1;
      fill <= '0;
      rd_arm <= 1'b0;
      wr_arm <= 1'b0;
    end else begin
      rd_s <= {rd_s[SYNC_STAGES-2:0], PIC_nRD};
      wr_s <= {wr_s[SYNC_STAGES-2:0], PIC_nWR};
      rd_h <= rd_sync;
      wr_h <= wr_sync;
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      rd_arm <= rd_arm | (fill[SYNC_STAGES-1] & rd_sync);
      wr_arm <= wr_arm | (fill[SYNC_STAGES-1] & wr_sync);
    end
  // hold the Atom write data while the synchronised write strobe is low
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cap <= 8'h00;
    else if (!wr_sync) cap <= PIC_Data_In;
  assign status = {busy, !tx_empty, rx_full, err, result};
  assign PIC_Data_OE = !PIC_nRD & !PIC_nEn;
  // read mux over registered state
  always_comb
    PIC_Data_Out = PIC_Addr[2] ? 8'hFF :
                   PIC_Addr[1:0] == 2'd0 ? status :
                   PIC_Addr[1:0] == 2'd1 ? latch :
                   PIC_Addr[1:0] == 2'd2 ? tx_head : 8'h00;
  assign wr_cmd = wr_edge & (PIC_Addr == 3'd0);
  assign wr_lat = wr_edge & (PIC_Addr == 3'd1);
  assign rx_push = wr_edge & (PIC_Addr == 3'd3);
  assign rd_stat = rd_edge & (PIC_Addr == 3'd0);
  assign rd_tx = rd_edge & (PIC_Addr == 3'd2);
  assign tx_pop = rd_tx & !tx_empty;
  assign tx_push = Tx_Valid & Tx_Ready;
  assign rx_pop = Rx_Valid & Rx_Ready;
  assign Tx_Ready = !tx_full;
  assign Rx_Valid = !rx_empty;
  assign busy_eff = busy & !Cmd_Done;
  assign accept = wr_cmd & !busy_eff;
  assign err_set = (rd_tx & tx_empty) | (rx_push & rx_full & !rx_pop) | (wr_cmd & busy_eff);
  // command handshake, latch and status flags; a same-cycle Done is applied before the command
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      Cmd_Code <= 8'h00;
      Cmd_Latch <= 8'h00;
      Cmd_Valid <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      result <= 4'h0;
      latch <= 8'h00;
    end else begin
      Cmd_Valid <= accept;
      if (accept) Cmd_Code <= cap;
      if (accept) Cmd_Latch <= latch;
      busy <= accept | busy_eff;
      if (Cmd_Done & busy) result <= Cmd_Result;
      if (wr_lat) latch <= cap;
      err <= err_set | (err & !rd_stat);
    end
  atommc_pic_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .Clk(Clk), .Reset(Reset), .push(tx_push), .pop(tx_pop), .wdata(Tx_Data),
    .rdata(tx_head), .empty(tx_empty), .full(tx_full)
  );
  atommc_pic_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .Clk(Clk), .Reset(Reset), .push(rx_push), .pop(rx_pop), .wdata(cap),
    .rdata(Rx_Data), .empty(rx_empty), .full(rx_full)
  );
endmodule

// File: tb/tb_atommc_pic_responder.sv
// tb_atommc_pic_responder: directed bench for the AtoMMC PIC register window
`timescale 1ns/1ps
module tb_atommc_pic_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic nrd = 1'b1, nwr = 1'b1, nen = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00, dout, cmd_code, cmd_latch, tx_data = 8'h00, rx_data;
  logic oe, cmd_valid, cmd_done = 1'b0, tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
  logic [3:0] cmd_result = 4'h0;
  logic [7:0] rd;
  int checks = 0, passed = 0, fails = 0, vcnt = 0, vsnap;

  atommc_pic_responder dut (
    .Clk(clk), .Reset(rst), .PIC_nRD(nrd), .PIC_nWR(nwr), .PIC_nEn(nen), .PIC_Addr(addr),
    .PIC_Data_In(din), .PIC_Data_Out(dout), .PIC_Data_OE(oe), .Cmd_Code(cmd_code),
    .Cmd_Latch(cmd_latch), .Cmd_Valid(cmd_valid), .Cmd_Done(cmd_done), .Cmd_Result(cmd_result),
    .Tx_Data(tx_data), .Tx_Valid(tx_valid), .Tx_Ready(tx_ready), .Rx_Data(rx_data),
    .Rx_Valid(rx_valid), .Rx_Ready(rx_ready)
  );

  always #31.25 clk = ~clk;

  always @(posedge clk) if (cmd_valid) vcnt <= vcnt + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic atom_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a;
    nrd = 1'b0;
    nen = 1'b0;
    repeat (7) @(negedge clk);
    d = dout;
    chk("read_oe", {7'd0, oe}, 8'h01);
    @(negedge clk);
    nrd = 1'b1;
    nen = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic atom_write(input logic [2:0] a, input logic [7:0] d, input logic co_done, input logic [3:0] res);
    @(negedge clk);
    addr = a;
    din = d;
    nwr = 1'b0;
    repeat (8) @(negedge clk);
    nwr = 1'b1;
    if (co_done) begin
      repeat (2) @(negedge clk);
      cmd_done = 1'b1;
      cmd_result = res;
      @(negedge clk);
      cmd_done = 1'b0;
      repeat (3) @(negedge clk);
    end else repeat (6) @(negedge clk);
  endtask

  task automatic done_pulse(input logic [3:0] res);
    @(negedge clk);
    cmd_done = 1'b1;
    cmd_result = res;
    @(negedge clk);
    cmd_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_oe", {7'd0, oe}, 8'h00);
    chk("rst_dout", dout, 8'h00);
    chk("rst_code", cmd_code, 8'h00);
    chk("rst_latch", cmd_latch, 8'h00);
    chk("rst_valid", {7'd0, cmd_valid}, 8'h00);
    chk("rst_txrdy", {7'd0, tx_ready}, 8'h01);
    chk("rst_rxvld", {7'd0, rx_valid}, 8'h00);
    chk("rst_rxdata", rx_data, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      atom_read(3'(i), rd);
      chk("map_read", rd, i < 4 ? 8'h00 : 8'hFF);
    end
    atom_read(3'd0, rd);
    chk("status_err_empty_tx", rd, 8'h10);

    atom_write(3'd1, 8'h5A, 1'b0, 4'h0);
    atom_read(3'd1, rd);
    chk("latch_read", rd, 8'h5A);
    vsnap = vcnt;
    atom_write(3'd0, 8'h20, 1'b0, 4'h0);
    chk("cmd_pulse", 8'(vcnt - vsnap), 8'h01);
    chk("cmd_code", cmd_code, 8'h20);
    chk("cmd_latch", cmd_latch, 8'h5A);
    atom_read(3'd0, rd);
    chk("status_busy", rd, 8'h80);
    atom_write(3'd0, 8'h21, 1'b0, 4'h0);
    chk("busy_no_pulse", 8'(vcnt - vsnap), 8'h01);
    chk("busy_code_kept", cmd_code, 8'h20);
    atom_read(3'd0, rd);
    chk("status_busy_err", rd, 8'h90);
    atom_read(3'd0, rd);
    chk("status_err_cleared", rd, 8'h80);
    atom_write(3'd0, 8'h30, 1'b1, 4'h5);
    chk("done_and_cmd_pulse", 8'(vcnt - vsnap), 8'h02);
    chk("done_and_cmd_code", cmd_code, 8'h30);
    atom_read(3'd0, rd);
    chk("status_done_and_cmd", rd, 8'h85);
    done_pulse(4'h3);
    atom_read(3'd0, rd);
    chk("status_done", rd, 8'h03);
    done_pulse(4'h9);
    atom_read(3'd0, rd);
    chk("status_idle_done_ignored", rd, 8'h03);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tx_ready_fill", {7'd0, tx_ready}, 8'h01);
      tx_valid = 1'b1;
      tx_data = 8'(i);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_full", {7'd0, tx_ready}, 8'h00);
    atom_read(3'd0, rd);
    chk("status_tx_nonempty", rd, 8'h43);
    for (int i = 0; i < 16; i++) begin
      atom_read(3'd2, rd);
      chk("tx_pop_data", rd, 8'(i));
    end
    chk("tx_ready_drained", {7'd0, tx_ready}, 8'h01);
    atom_read(3'd0, rd);
    chk("status_tx_empty", rd, 8'h03);
    atom_read(3'd2, rd);
    chk("tx_empty_read", rd, 8'h00);
    atom_read(3'd0, rd);
    chk("status_tx_underflow", rd, 8'h13);

    for (int i = 0; i < 17; i++) atom_write(3'd3, 8'hA0 + 8'(i), 1'b0, 4'h0);
    chk("rx_valid_full", {7'd0, rx_valid}, 8'h01);
    atom_read(3'd0, rd);
    chk("status_rx_overflow", rd, 8'h33);
    @(negedge clk);
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("rx_data", rx_data, 8'hA0 + 8'(i));
      @(negedge clk);
    end
    rx_ready = 1'b0;
    chk("rx_valid_drained", {7'd0, rx_valid}, 8'h00);
    atom_read(3'd0, rd);
    chk("status_rx_drained", rd, 8'h03);

    vsnap = vcnt;
    @(negedge clk);
    addr = 3'd0;
    din = 8'h40;
    nwr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    nwr = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_pulse", 8'(vcnt - vsnap), 8'h00);
    chk("rst_mid_code", cmd_code, 8'h00);
    atom_read(3'd0, rd);
    chk("rst_mid_status", rd, 8'h00);
    atom_write(3'd0, 8'h41, 1'b0, 4'h0);
    chk("post_rst_pulse", 8'(vcnt - vsnap), 8'h01);
    chk("post_rst_code", cmd_code, 8'h41);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/atommc_pic_responder.md
Name: atommc_pic_responder

Overview:
- PIC-side responder for the AtoMMC register window at #B400-#B407.
- Consumes PIC_nRD, PIC_nWR, PIC_nEn, PIC_Addr and the Atom data bus as driven by the CPLD decode logic. Resynchronises the strobes into the local clock domain.
- Implements command, latch, status and two data FIFOs, with a valid/ready handshake to the local storage controller.
- Stands in for the PIC firmware register interface in programmable logic.

Parameters:
- FIFO_DEPTH, 16, entries per data FIFO (power of two, 4..64).
- SYNC_STAGES, 2, flops in each strobe synchroniser (2..3).

Ports:
- Clk  input  1  system clock, at least 8x Atom_Phi2.
- Reset  input  1  asynchronous, active-high reset.
- PIC_nRD  input  1  read strobe, low during an Atom read of #B400-#B407; asynchronous to Clk.
- PIC_nWR  input  1  write strobe, low during an Atom write; asynchronous to Clk.
- PIC_nEn  input  1  window enable; used only to gate PIC_Data_OE.
- PIC_Addr  input  3  latched register address; stable for the whole access.
- PIC_Data_In  input  8  Atom data bus, input side.
- PIC_Data_Out  output  8  Atom data bus, output side.
- PIC_Data_OE  output  1  data bus output enable.
- Cmd_Code  output  8  last accepted command byte.
- Cmd_Latch  output  8  latch register value captured at command accept.
- Cmd_Valid  output  1  one-Clk pulse when a command is accepted.
- Cmd_Done  input  1  one-Clk pulse from the controller: command finished.
- Cmd_Result  input  4  result code; sampled when Cmd_Done is high.
- Tx_Data  input  8  controller-to-Atom byte.
- Tx_Valid  input  1  Tx_Data is valid.
- Tx_Ready  output  1  TX FIFO not full.
- Rx_Data  output  8  Atom-to-controller byte (head of RX FIFO).
- Rx_Valid  output  1  RX FIFO not empty.
- Rx_Ready  input  1  controller pops the RX FIFO.

Behaviour:
- Reset values:
  - Outputs: PIC_Data_OE=0, PIC_Data_Out=0x00, Cmd_Code=0x00, Cmd_Latch=0x00, Cmd_Valid=0, Tx_Ready=1, Rx_Valid=0, Rx_Data=0x00.
  - Internal: FIFOs empty, Busy=0, Err=0, Result=0, Latch=0.
  - Synchroniser flops reset to 1 (strobes inactive).
  - Reset mid-access: no spurious edge is generated after release.
- Strobe synchronisation:
  - nRD and nWR each pass through SYNC_STAGES flops plus one history flop.
  - A rising edge of the synchronised strobe marks the end of an access.
- Write data capture:
  - While synchronised nWR=0, a capture register loads PIC_Data_In every Clk.
  - On the synchronised nWR rising edge, the write commits using the held value and PIC_Addr.
- Read path:
  - PIC_Data_OE = !PIC_nRD & !PIC_nEn, combinational.
  - PIC_Data_Out is a combinational mux on PIC_Addr of registered state, so it is valid within one mux delay of PIC_Addr settling.
  - Side effects (pop, flag clear) occur on the synchronised nRD rising edge, i.e. after the Atom has sampled the data.
- Register map (read / write):
  - 0: STATUS / CMD.
    - STATUS bits: [7]=Busy, [6]=TX non-empty, [5]=RX full, [4]=Err, [3:0]=Result.
    - A STATUS read clears Err at the nRD edge.
  - 1: LATCH / LATCH. Read returns the latch; write sets it.
  - 2: TX FIFO head / ignored.
    - Read pops at the edge.
    - Empty read returns 0x00, does not pop and sets Err.
  - 3: 0x00 / RX FIFO push.
    - Write to a full FIFO drops the byte and sets Err.
  - 4-7: 0xFF / ignored; no side effects.
- Command handshake:
  - CMD write with Busy=0: Cmd_Code<=data, Cmd_Latch<=Latch, Busy<=1, Cmd_Valid=1 for exactly one Clk.
  - CMD write with Busy=1: ignored, sets Err.
  - Cmd_Done with Busy=1: Busy<=0, Result<=Cmd_Result.
  - Cmd_Done with Busy=0: ignored.
  - Cmd_Done and a CMD commit in the same Clk: Done is applied first, then the command is accepted. Busy stays 1, Cmd_Valid pulses, and Result takes Cmd_Result.
- FIFOs:
  - Synchronous, FIFO_DEPTH entries; pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
  - TX push when Tx_Valid & Tx_Ready.
  - RX pop when Rx_Valid & Rx_Ready.
  - Simultaneous push and pop on a full or empty FIFO behaves as follows:
    - Full: pop then push; both succeed, count is unchanged.
    - Empty: push only; the output becomes valid the next Clk.
  - Rx_Data and the TX head are first-word-fall-through, registered.
- Latency:
  - Strobe edge to internal commit: SYNC_STAGES+1 Clk.
  - Cmd_Valid asserts in the commit Clk.
  - Status reflects a change on the Clk after the change.

Test Plan:
- Reset, then read each address 0-7 with nRD pulses of 500 ns at 16 MHz Clk -> 0x00, 0x00, 0x00, 0x00, 0xFF, 0xFF, 0xFF, 0xFF; Err then reads 1 in STATUS, because the read of address 2 hit an empty TX FIFO.
- Write LATCH=0x5A, then CMD=0x20 -> one Cmd_Valid pulse with Cmd_Code=0x20, Cmd_Latch=0x5A; STATUS=0x80. Cmd_Done with Cmd_Result=0x3 -> STATUS=0x03.
- With Busy=1, write CMD=0x21 -> no Cmd_Valid, Cmd_Code stays 0x20, STATUS bit4=1. A second STATUS read shows bit4=0.
- Push 16 bytes 0x00..0x0F on Tx (Tx_Ready low after the 16th), then 17 Atom reads of address 2 -> 0x00..0x0F in order; the 17th returns 0x00 and sets Err. STATUS bit6 falls after the 16th read.
- Atom writes 17 bytes 0xA0..0xB0 to address 3 with Rx_Ready=0 -> 16 stored, STATUS bit5=1, Err=1. Assert Rx_Ready -> Rx_Data sequence 0xA0..0xAF.
- Assert Reset while PIC_nWR=0 mid-CMD write, release before nWR rises -> no Cmd_Valid and Busy=0 after the strobe returns high.
